edge_bit_packer: RTL
====================

EDGE_BIT_PACKER -- requirements
Module: edge_bit_packer

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, byte FIFO entries (power of two, 2..16).
REQ-002 Parameter PX_BITS, default MAX_PIXEL_BITS, width of the incoming pixel bus.
REQ-003 clk_i  in  1  single clock; all state on its rising edge.
REQ-004 nreset_i  in  1  reset, asynchronous, active-low.
REQ-005 px_rdy_i  in  1  one-cycle strobe; px_i valid (Sobel px_rdy_o).
REQ-006 px_i  in  PX_BITS  Sobel output pixel (out_pixel_o); only bits [7:0] used.
REQ-007 threshold_i  in  8  edge threshold, quasi-static.
REQ-008 flush_i  in  1  one-cycle strobe; emit partial byte.
REQ-009 byte_o  out  8  FIFO head byte.
REQ-010 byte_rdy_o  out  1  high while FIFO is non-empty.
REQ-011 byte_ack_i  in  1  consumer pops head when byte_rdy_o is high; ignored when empty.
REQ-012 fifo_full_o  out  1  FIFO holds FIFO_DEPTH bytes.
REQ-013 overflow_o  out  1  sticky, a packed byte was dropped.
REQ-014 edge_count_o  out  16  edge-pixel count (present only with EDGE_COUNT_EN).

Function
REQ-015 Edge bit = (px_i[7:0] >= threshold_i), sampled on px_rdy_i.
REQ-016 Bits packed MSB-first: first pixel after reset/push -> bit 7, eighth -> bit 0.
REQ-017 3-bit bit counter; shift register holds partial byte.
REQ-018 Packer states: PACK (accumulating) and PUSH (byte pending write); PUSH lasts exactly one cycle, then PACK.
REQ-019 8th strobe -> PUSH; byte written to FIFO on the following edge; byte_rdy_o high 2 cycles after the 8th strobe edge if FIFO was empty.
REQ-020 px_rdy_i during PUSH is accepted as bit 7 of the next byte, no stall, no loss.
REQ-021 flush_i with counter > 0 -> PUSH of partial byte, unfilled low bits zero; counter cleared.
REQ-022 flush_i with counter = 0 -> no effect.
REQ-023 flush_i with px_rdy_i same cycle -> pixel included first; if that completes 8 bits, exactly one push.
REQ-024 Push with FIFO full and no simultaneous pop -> byte dropped, overflow_o set; cleared only by reset.
REQ-025 Simultaneous push and pop when full -> both occur, no overflow, fifo_full_o stays high.
REQ-026 Simultaneous push and pop when empty -> push only (pop ignored).
REQ-027 Read/write pointers wrap modulo FIFO_DEPTH; byte order preserved.
REQ-028 byte_o equals head entry combinationally from registered storage; undefined value masked to 0 when empty.

Reset
REQ-029 nreset_i low: counter 0, shift register 0, state PACK, FIFO empty, byte_o 0, byte_rdy_o 0, fifo_full_o 0, overflow_o 0, edge_count_o 0.
REQ-030 Reset mid-byte discards partial bits and FIFO contents; first strobe after release -> bit 7.

Configuration
REQ-031 Macro EDGE_COUNT_EN defined: edge_count_o increments on each strobe with edge bit 1, saturates at 16'hFFFF, cleared by reset only.
REQ-032 Macro undefined: edge_count_o port and counter absent; all other behaviour identical.

Structure
REQ-033 PACK_BITS (8), default FIFO_DEPTH, and packer state enum reside in the shared parameters package.
REQ-034 FIFO is sub-module edge_byte_fifo (push, pop, data in/out, empty, full); packer logic in edge_bit_packer.

Verification
REQ-035 threshold 0x80; pixels 0x80,0x00,0xFF,0x7F,0x90,0x10,0xA0,0x81 -> byte_o 0xAB, byte_rdy_o high 2 cycles after 8th strobe.
REQ-036 threshold 0x10; 3 pixels 0xFF then flush_i -> byte 0xE0; second flush_i -> no push.
REQ-037 FIFO_DEPTH 4, no ack, 5 full bytes -> fifo_full_o 1, overflow_o 1, bytes 1-4 read back in order.
REQ-038 FIFO full, push with byte_ack_i same cycle -> overflow_o stays 0, new byte read last.
REQ-039 Reset asserted after 5 strobes, release, 8 pixels 0xFF at threshold 0 -> single byte 0xFF.
REQ-040 EDGE_COUNT_EN, threshold 0, 70000 strobes -> edge_count_o 16'hFFFF.

Source files
------------

// File: rtl/edge_bit_packer_pkg.sv
// Shared parameters and types for the edge bit packer.
package edge_bit_packer_pkg;

  localparam int PACK_BITS          = 8;
  localparam int DEFAULT_FIFO_DEPTH = 4;
  localparam int MAX_PIXEL_BITS     = 8;

  typedef enum logic {
    ST_PACK = 1'b0,
    ST_PUSH = 1'b1
  } pack_state_t;

endpackage

// File: rtl/edge_bit_packer_if.sv
// Pixel-in / byte-out handshake bundle for the edge bit packer.
interface edge_bit_packer_if
  import edge_bit_packer_pkg::*;
#(
  parameter int PX_BITS = MAX_PIXEL_BITS
);

  logic               px_rdy_i;
  logic [PX_BITS-1:0] px_i;
  logic [7:0]         threshold_i;
  logic               flush_i;
  logic [7:0]         byte_o;
  logic               byte_rdy_o;
  logic               byte_ack_i;
  logic               fifo_full_o;
  logic               overflow_o;

  modport master (
    output px_rdy_i, px_i, threshold_i, flush_i, byte_ack_i,
    input  byte_o, byte_rdy_o, fifo_full_o, overflow_o
  );

  modport slave (
    input  px_rdy_i, px_i, threshold_i, flush_i, byte_ack_i,
    output byte_o, byte_rdy_o, fifo_full_o, overflow_o
  );

endinterface

// File: rtl/edge_byte_fifo.sv
// Byte FIFO with power-of-two depth; head is presented combinationally
// and masked to zero while empty. A pop on an empty FIFO is ignored, and a
// push into a full FIFO only lands when a pop frees the slot the same cycle.
module edge_byte_fifo
  import edge_bit_packer_pkg::*;
#(
  parameter int DEPTH = DEFAULT_FIFO_DEPTH
) (
  input  logic                 clk_i,
  input  logic                 nreset_i,
  input  logic                 push,
  input  logic                 pop,
  input  logic [PACK_BITS-1:0] din,
  output logic [PACK_BITS-1:0] dout,
  output logic                 empty,
  output logic                 full
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [PACK_BITS-1:0] mem [DEPTH];
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic [AW:0]          count;
  logic                 do_push;
  logic                 do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = empty ? '0 : mem[rd_ptr];

  // Storage write; contents are don't-care until counted valid.
  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/edge_bit_packer.sv
// Thresholds pixels into edge bits, packs them MSB-first into bytes and
// queues the bytes in edge_byte_fifo. Optional macro EDGE_COUNT_EN adds a
// saturating edge-pixel counter on edge_count_o.
//
// state   | meaning
// PACK    | accumulating bits into the shift register
// PUSH    | completed/flushed byte in push_byte is written to the FIFO
module edge_bit_packer
  import edge_bit_packer_pkg::*;
#(
  parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH,
  parameter int PX_BITS    = MAX_PIXEL_BITS
) (
  input  logic                 clk_i,
  input  logic                 nreset_i,
  edge_bit_packer_if.slave     bus
`ifdef EDGE_COUNT_EN
  ,
  output logic [15:0]          edge_count_o
`endif
);

  pack_state_t          state, state_d;
  logic [2:0]           bit_cnt, cnt_d;
  logic [PACK_BITS-1:0] shift_reg, shift_d;
  logic [PACK_BITS-1:0] push_byte, push_byte_d;
  logic [PACK_BITS-1:0] merged;
  logic [PX_BITS-1:0]   px_word;
  logic                 edge_bit;
  logic                 fifo_push;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 overflow;

  assign px_word  = bus.px_i;
  assign edge_bit = (px_word[7:0] >= bus.threshold_i);
  assign merged   = shift_reg | ({7'b0, edge_bit} << (3'd7 - bit_cnt));

  // State, bit counter, partial byte and pending byte registers.
  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      state     <= ST_PACK;
      bit_cnt   <= '0;
      shift_reg <= '0;
      push_byte <= '0;
    end else begin
      state     <= state_d;
      bit_cnt   <= cnt_d;
      shift_reg <= shift_d;
      push_byte <= push_byte_d;
    end
  end

  // Next state: the pixel is folded in first, then a flush acts on what is
  // left. A strobe during PUSH is simply the first bit of the next byte,
  // since push_byte is consumed by the FIFO on the same edge it is reloaded.
  always_comb begin
    state_d     = ST_PACK;
    cnt_d       = bit_cnt;
    shift_d     = shift_reg;
    push_byte_d = push_byte;
    if (bus.px_rdy_i) begin
      if (bit_cnt == 3'd7) begin
        push_byte_d = merged;
        state_d     = ST_PUSH;
        cnt_d       = '0;
        shift_d     = '0;
      end else begin
        cnt_d   = bit_cnt + 3'd1;
        shift_d = merged;
      end
    end
    if (bus.flush_i && (cnt_d != 3'd0)) begin
      push_byte_d = shift_d;
      state_d     = ST_PUSH;
      cnt_d       = '0;
      shift_d     = '0;
    end
  end

  assign fifo_push = (state == ST_PUSH);

  edge_byte_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i    (clk_i),
    .nreset_i (nreset_i),
    .push     (fifo_push),
    .pop      (bus.byte_ack_i),
    .din      (push_byte),
    .dout     (bus.byte_o),
    .empty    (fifo_empty),
    .full     (fifo_full)
  );

  // Sticky flag for a byte lost to a full FIFO with no pop alongside it.
  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i)                                      overflow <= 1'b0;
    else if (fifo_push && fifo_full && !bus.byte_ack_i) overflow <= 1'b1;
  end

  assign bus.byte_rdy_o  = !fifo_empty;
  assign bus.fifo_full_o = fifo_full;
  assign bus.overflow_o  = overflow;

`ifdef EDGE_COUNT_EN
  logic [15:0] edge_cnt;

  // Saturating count of strobes whose edge bit is set.
  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i)
      edge_cnt <= '0;
    else if (bus.px_rdy_i && edge_bit && (edge_cnt != 16'hFFFF))
      edge_cnt <= edge_cnt + 16'd1;
  end

  assign edge_count_o = edge_cnt;
`endif

endmodule
